// File: rtl/serial2tcp_stream_checker_if.sv
// Byte-stream handshake between the serial2tcp loopback source port and the
// stream checker. The producer owns valid/data and the consumer owns ready.
interface serial2tcp_stream_checker_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/serial2tcp_stream_checker.sv
// Consumer end of the serial2tcp byte stream. It accepts bytes under optional
// pseudo-random backpressure and checks that they form a modulo-256
// incrementing sequence. It reports lock state, byte count and error statistics.
module serial2tcp_stream_checker #(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          LOCK_THRESH = 4,
  parameter int          LOSS_THRESH = 2,
  parameter int          ERR_CNT_W   = 16
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  serial2tcp_stream_checker_if.slave   sink,
  input  logic                         bp_enable,
  input  logic                         clear,
  output logic                         locked,
  output logic [31:0]                  byte_count,
  output logic [ERR_CNT_W-1:0]         error_count,
  output logic [7:0]                   last_bad_data,
  output logic [7:0]                   last_expected
);

  typedef enum logic [0:0] {
    ST_HUNT  = 1'b0,
    ST_CHECK = 1'b1
  } state_t;

  localparam int GW = $clog2(LOCK_THRESH + 1);
  localparam int BW = $clog2(LOSS_THRESH + 1);
  localparam logic [GW-1:0]        LOCK_MAX = GW'(LOCK_THRESH);
  localparam logic [BW-1:0]        LOSS_MAX = BW'(LOSS_THRESH);
  localparam logic [GW-1:0]        GOOD_ONE = GW'(1'b1);
  localparam logic [BW-1:0]        BAD_ONE  = BW'(1'b1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1'b1);

  // Fibonacci LFSR step with taps 16,14,13,11 (1-based), shifting left.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  logic [15:0]          lfsr_r;
  logic                 sink_ready_r;
  state_t               state_r;
  logic [7:0]           expected_r;
  logic [GW-1:0]        good_run_r;
  logic [BW-1:0]        bad_run_r;
  logic                 locked_r;
  logic [31:0]          byte_count_r;
  logic [ERR_CNT_W-1:0] error_count_r;
  logic [7:0]           last_bad_data_r;
  logic [7:0]           last_expected_r;

  logic                 xfer_s;
  logic [7:0]           data_inc_s;
  logic [GW-1:0]        good_inc_s;
  logic [BW-1:0]        bad_inc_s;
  logic [ERR_CNT_W-1:0] err_inc_s;

  assign sink.ready    = sink_ready_r;
  assign locked        = locked_r;
  assign byte_count    = byte_count_r;
  assign error_count   = error_count_r;
  assign last_bad_data = last_bad_data_r;
  assign last_expected = last_expected_r;

  // Free-running backpressure LFSR and registered ready. Only sys_rst affects them; clear does not.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      lfsr_r       <= LFSR_SEED;
      sink_ready_r <= 1'b0;
    end else begin
      lfsr_r       <= lfsr_step(lfsr_r);
      sink_ready_r <= ~bp_enable | (lfsr_r[1:0] != 2'b00);
    end
  end

  // Handshake detection and saturating increments for the run and error counters.
  always_comb begin
    xfer_s     = sink.valid & sink_ready_r;
    data_inc_s = sink.data + 8'd1;
    if (good_run_r >= LOCK_MAX) begin
      good_inc_s = LOCK_MAX;
    end else begin
      good_inc_s = good_run_r + GOOD_ONE;
    end
    if (bad_run_r >= LOSS_MAX) begin
      bad_inc_s = LOSS_MAX;
    end else begin
      bad_inc_s = bad_run_r + BAD_ONE;
    end
    if (error_count_r == ERR_MAX) begin
      err_inc_s = ERR_MAX;
    end else begin
      err_inc_s = error_count_r + ERR_ONE;
    end
  end

  // Sequence checker FSM and statistics. Clear behaves as a soft reset and drops a coincident transfer.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || clear) begin
      state_r         <= ST_HUNT;
      expected_r      <= 8'h00;
      good_run_r      <= {GW{1'b0}};
      bad_run_r       <= {BW{1'b0}};
      locked_r        <= 1'b0;
      byte_count_r    <= 32'd0;
      error_count_r   <= {ERR_CNT_W{1'b0}};
      last_bad_data_r <= 8'h00;
      last_expected_r <= 8'h00;
    end else if (xfer_s) begin
      byte_count_r <= byte_count_r + 32'd1;
      // Always resynchronise on the received byte, so a dropped byte costs exactly one error.
      expected_r   <= data_inc_s;
      case (state_r)
        ST_HUNT: begin
          good_run_r <= GOOD_ONE;
          bad_run_r  <= {BW{1'b0}};
          state_r    <= ST_CHECK;
        end
        ST_CHECK: begin
          if (sink.data == expected_r) begin
            good_run_r <= good_inc_s;
            bad_run_r  <= {BW{1'b0}};
            if (good_inc_s == LOCK_MAX) begin
              locked_r <= 1'b1;
            end
          end else begin
            error_count_r   <= err_inc_s;
            last_bad_data_r <= sink.data;
            last_expected_r <= expected_r;
            good_run_r      <= {GW{1'b0}};
            bad_run_r       <= bad_inc_s;
            if (bad_inc_s == LOSS_MAX) begin
              locked_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= ST_HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial2tcp_stream_checker.sv
// Bench for serial2tcp_stream_checker. A reference model runs on every rising
// edge and pushes the expected outputs into a scoreboard queue. A monitor pops
// that queue on each falling edge and compares it against the DUT. Directed
// sections follow the stream scenarios, and a randomized section mixes
// counter bytes, corrupt and skipped bytes, idles, clears and resets.
module tb_serial2tcp_stream_checker;

  localparam logic [15:0] SEED   = 16'hACE1;
  localparam int          LOCK_T = 4;
  localparam int          LOSS_T = 2;
  localparam int          ERR_W  = 16;

  logic             sys_clk;
  logic             sys_rst;
  logic             bp_enable;
  logic             clear;
  logic             locked;
  logic [31:0]      byte_count;
  logic [ERR_W-1:0] error_count;
  logic [7:0]       last_bad_data;
  logic [7:0]       last_expected;

  serial2tcp_stream_checker_if sink();

  serial2tcp_stream_checker #(
    .LFSR_SEED  (SEED),
    .LOCK_THRESH(LOCK_T),
    .LOSS_THRESH(LOSS_T),
    .ERR_CNT_W  (ERR_W)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .sink         (sink),
    .bp_enable    (bp_enable),
    .clear        (clear),
    .locked       (locked),
    .byte_count   (byte_count),
    .error_count  (error_count),
    .last_bad_data(last_bad_data),
    .last_expected(last_expected)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic             ready;
    logic             locked;
    logic [31:0]      bytes;
    logic [ERR_W-1:0] errs;
    logic [7:0]       lbad;
    logic [7:0]       lexp;
  } exp_t;

  exp_t sb_q[$];

  logic [15:0]      m_lfsr;
  logic             m_ready;
  bit               m_have_prev;
  logic [7:0]       m_next;
  int               m_good;
  int               m_bad;
  logic             m_locked;
  logic [31:0]      m_bytes;
  logic [ERR_W-1:0] m_err;
  logic [7:0]       m_lbad;
  logic [7:0]       m_lexp;

  task automatic model_clear();
    m_have_prev = 1'b0;
    m_next      = 8'h00;
    m_good      = 0;
    m_bad       = 0;
    m_locked    = 1'b0;
    m_bytes     = 32'd0;
    m_err       = '0;
    m_lbad      = 8'h00;
    m_lexp      = 8'h00;
  endtask

  task automatic model_accept(input logic [7:0] d);
    m_bytes = m_bytes + 32'd1;
    if (!m_have_prev) begin
      m_have_prev = 1'b1;
      m_good      = 1;
      m_bad       = 0;
    end else if (d == m_next) begin
      m_good = m_good + 1;
      m_bad  = 0;
      if (m_good >= LOCK_T) m_locked = 1'b1;
    end else begin
      if (m_err != {ERR_W{1'b1}}) m_err = m_err + 1'b1;
      m_lbad = d;
      m_lexp = m_next;
      m_good = 0;
      m_bad  = m_bad + 1;
      if (m_bad >= LOSS_T) m_locked = 1'b0;
    end
    m_next = d + 8'd1;
  endtask

  task automatic model_step();
    logic xfer;
    logic new_ready;
    exp_t e;
    if (sys_rst) begin
      m_lfsr  = SEED;
      m_ready = 1'b0;
      model_clear();
    end else begin
      xfer      = sink.valid && m_ready;
      new_ready = !bp_enable || (m_lfsr % 16'd4 != 16'd0);
      m_lfsr    = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      m_ready   = new_ready;
      if (clear) model_clear();
      else if (xfer) model_accept(sink.data);
    end
    e.ready  = m_ready;
    e.locked = m_locked;
    e.bytes  = m_bytes;
    e.errs   = m_err;
    e.lbad   = m_lbad;
    e.lexp   = m_lexp;
    sb_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge sys_clk);
      model_step();
    end
  end

  // Monitor: compares registered outputs away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_ready",   {31'd0, sink.ready},   {31'd0, e.ready});
        check("sb_locked",  {31'd0, locked},       {31'd0, e.locked});
        check("sb_bytes",   byte_count,            e.bytes);
        check("sb_errors",  {16'd0, error_count},  {16'd0, e.errs});
        check("sb_lastbad", {24'd0, last_bad_data}, {24'd0, e.lbad});
        check("sb_lastexp", {24'd0, last_expected}, {24'd0, e.lexp});
      end
    end
  end

  // ---------------- stimulus ----------------
  int g_cyc = 0;
  int g_rdy = 0;

  // Offer byte b and hold it stable until it is accepted. Called at a falling edge.
  task automatic send(input logic [7:0] b);
    logic rdy;
    int   n;
    n          = 0;
    sink.valid = 1'b1;
    sink.data  = b;
    do begin
      rdy = sink.ready;
      g_cyc++;
      if (rdy) g_rdy++;
      @(negedge sys_clk);
      n++;
    end while (!rdy && n < 100);
    check("send_accept", {31'd0, rdy}, 32'd1);
  endtask

  task automatic idle(input int n);
    sink.valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      sink.data = 8'($urandom);
      @(negedge sys_clk);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge sys_clk);
    clear = 1'b0;
  endtask

  task automatic pulse_reset();
    sink.valid = 1'b0;
    sys_rst    = 1'b1;
    @(negedge sys_clk);
    sys_rst    = 1'b0;
  endtask

  initial begin
    logic [7:0] nxt;
    int         nsent;
    int         r;
    logic [31:0] duty_ok;
    sys_rst    = 1'b1;
    clear      = 1'b0;
    bp_enable  = 1'b0;
    sink.valid = 1'b0;
    sink.data  = 8'h00;
    repeat (3) @(negedge sys_clk);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_bytes",  byte_count,      32'd0);
    sys_rst = 1'b0;

    // Sequence and lock
    for (int i = 0; i < 16; i++) begin
      send(8'(i));
      if (i == 2) check("lock_after_3", {31'd0, locked}, 32'd0);
      if (i == 3) check("lock_after_4", {31'd0, locked}, 32'd1);
    end
    check("seq_bytes",  byte_count,           32'd16);
    check("seq_errors", {16'd0, error_count}, 32'd0);

    // Counter wrap
    pulse_clear();
    send(8'hFD); send(8'hFE); send(8'hFF); send(8'h00); send(8'h01);
    check("wrap_errors", {16'd0, error_count}, 32'd0);
    check("wrap_locked", {31'd0, locked},      32'd1);
    check("wrap_bytes",  byte_count,           32'd5);

    // Dropped byte
    pulse_clear();
    for (int v = 8'h10; v <= 8'h1A; v++) if (v != 8'h15) send(8'(v));
    check("drop_errors",  {16'd0, error_count},   32'd1);
    check("drop_lastbad", {24'd0, last_bad_data}, 32'h16);
    check("drop_lastexp", {24'd0, last_expected}, 32'h15);
    check("drop_locked",  {31'd0, locked},        32'd1);

    // Lock loss and recovery
    send(8'h20);
    check("loss1_locked", {31'd0, locked}, 32'd1);
    send(8'h55);
    check("loss2_errors", {16'd0, error_count}, 32'd3);
    check("loss2_locked", {31'd0, locked},      32'd0);
    send(8'h56); send(8'h57); send(8'h58);
    check("recov3_locked", {31'd0, locked}, 32'd0);
    send(8'h59);
    check("recov4_locked", {31'd0, locked}, 32'd1);
    check("recov_bytes",   byte_count,      32'd16);

    // Backpressure, valid held high
    bp_enable = 1'b1;
    g_cyc = 0;
    g_rdy = 0;
    nsent = 0;
    nxt   = 8'h5A;
    while (g_cyc < 1000) begin
      send(nxt);
      nxt++;
      nsent++;
    end
    duty_ok = ((g_rdy * 10 >= g_cyc * 7) && (g_rdy * 10 <= g_cyc * 8)) ? 32'd1 : 32'd0;
    if (duty_ok != 32'd1) $display("ready duty %0d of %0d cycles", g_rdy, g_cyc);
    check("bp_duty",   duty_ok,              32'd1);
    check("bp_bytes",  byte_count,           32'(16 + nsent));
    check("bp_errors", {16'd0, error_count}, 32'd3);

    // Clear and reset together: reset wins, LFSR restarts from seed
    sys_rst = 1'b1;
    clear   = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    clear   = 1'b0;
    check("both_locked",  {31'd0, locked},        32'd0);
    check("both_bytes",   byte_count,             32'd0);
    check("both_errors",  {16'd0, error_count},   32'd0);
    check("both_lastbad", {24'd0, last_bad_data}, 32'd0);
    check("both_lastexp", {24'd0, last_expected}, 32'd0);
    send(8'h77);
    check("rehunt_errors", {16'd0, error_count}, 32'd0);
    idle(2);
    pulse_clear();
    idle(6);

    // Randomized mix
    nxt = 8'($urandom);
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 19) == 0) bp_enable = ~bp_enable;
      if (r < 70) begin
        send(nxt);
        nxt++;
      end else if (r < 78) begin
        send(8'($urandom));
      end else if (r < 86) begin
        nxt++;
      end else if (r < 93) begin
        idle($urandom_range(1, 3));
      end else if (r < 98) begin
        pulse_clear();
      end else begin
        pulse_reset();
      end
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial2tcp_stream_checker.md
Name: serial2tcp_stream_checker

Overview:
- Consumer end of the serial2tcp byte stream: sits on the loopback's source port, opposite the counter generator that feeds the sink port.
- Accepts bytes through a valid/ready handshake and applies optional pseudo-random backpressure.
- Checks that the accepted bytes form a modulo-256 incrementing sequence, and reports lock status, byte count and error statistics for simulation and hardware self-test.

Parameters:
- LFSR_SEED, 16'hACE1: reset value of the backpressure LFSR. Must be nonzero.
- LOCK_THRESH, 4: number of consecutive good bytes required to assert locked.
- LOSS_THRESH, 2: number of consecutive bad bytes that deassert locked.
- ERR_CNT_W, 16: width of error_count. The counter saturates.

Ports:
- sys_clk, input, 1: single clock; all logic is on the rising edge.
- sys_rst, input, 1: synchronous, active-high reset.
- sink_valid, input, 1: byte present, driven by serial2tcp source_valid.
- sink_ready, output, 1: checker accepts the byte; drives serial2tcp source_ready.
- sink_data, input, 8: byte value.
- bp_enable, input, 1: 1 = random backpressure, 0 = always ready.
- clear, input, 1: synchronous clear of statistics and state machine; LFSR unaffected.
- locked, output, 1: sequence lock indicator.
- byte_count, output, 32: total accepted bytes; wraps at 2^32.
- error_count, output, ERR_CNT_W: mismatched bytes; saturates at all-ones.
- last_bad_data, output, 8: data of the most recent mismatched byte.
- last_expected, output, 8: expected value at the most recent mismatch.

Behaviour:
- Reset (sys_rst=1 on a clock edge):
  - sink_ready=0, locked=0, byte_count=0, error_count=0, last_bad_data=0, last_expected=0.
  - State=HUNT, expected=0, good_run=0, bad_run=0, lfsr=LFSR_SEED.
- Acceptance: a byte is accepted on an edge where sink_valid & sink_ready = 1. Nothing else is a transfer. The checker never inspects sink_data when no transfer occurs.
- LFSR and sink_ready:
  - LFSR is a 16-bit Fibonacci LFSR, taps 16,14,13,11. It shifts every cycle out of reset, regardless of handshake.
  - sink_ready is registered: next value = ~bp_enable | (lfsr[1:0] != 2'b00).
  - Therefore ready follows bp_enable with 1 cycle latency, and is about 75% duty when enabled.
  - sink_ready is independent of sink_valid. There is no combinational path from input to output.
- Statistics: all outputs are registered and update on the edge after the accepting edge (1-cycle latency). byte_count increments on every transfer.
- State HUNT:
  - On a transfer: expected <= sink_data+1 (mod 256), good_run <= 1, bad_run <= 0, state <= CHECK. No error is counted.
- State CHECK, on a transfer:
  - If sink_data == expected: good_run++ (saturate at LOCK_THRESH), bad_run <= 0. locked <= 1 when good_run reaches LOCK_THRESH.
  - If sink_data != expected: error_count++ (saturating); last_bad_data <= sink_data; last_expected <= expected; good_run <= 0; bad_run++ (saturate at LOSS_THRESH). locked <= 0 when bad_run reaches LOSS_THRESH.
  - In both cases expected <= sink_data+1. This resynchronises immediately, so one dropped byte costs exactly one error.
- Wrap-around: data 8'hFF followed by 8'h00 is a match. byte_count wraps 32'hFFFFFFFF -> 0. error_count holds at all-ones.
- clear=1:
  - Same effect as reset, except the LFSR and sink_ready continue as normal.
  - A transfer coincident with clear is dropped and not counted.
  - sys_rst has priority over clear.
- Reset mid-stream: the in-flight byte is not accepted (sink_ready=0). After reset the checker re-hunts from the next byte, and no error is counted for the discontinuity.

Test Plan:
- Sequence and lock: bp_enable=0, counter source 0x00..0x0F continuous → sink_ready=1 from the 2nd cycle after reset; locked=1 one cycle after the 4th byte (0x03) is accepted; byte_count=16, error_count=0.
- Counter wrap: drive 0xFD,0xFE,0xFF,0x00,0x01 → error_count=0, locked=1.
- Dropped byte: drive 0x10..0x14, skip 0x15, then 0x16..0x1A → error_count=1, last_bad_data=0x16, last_expected=0x15, locked stays 1 (LOSS_THRESH=2).
- Lock loss and recovery: inject two consecutive wrong bytes, e.g. 0x20 then 0x55 after 0x1A → error_count +2, locked=0; four further in-order bytes → locked=1.
- Backpressure: bp_enable=1, sink_valid held high for 1000 cycles → ready duty 70–80%; bytes counted equal ready cycles exactly; no errors; sink_data is held stable while valid & ~ready.
- Clear and reset priority: assert clear and sys_rst in the same cycle mid-stream → all statistics are 0 and state is HUNT. The LFSR equals LFSR_SEED because reset wins. Clear alone leaves the LFSR sequence continuing.
